mosaic_ctrl: RTL and testbench
==============================

# mosaic_ctrl

Multi-channel, parametrised BG mosaic controller for the PPU. It generates per-background pixel-hold strobes and horizontal/vertical coordinate subtract values, with a shared X/Y block counter pair. It adds boundary-synchronised size changes, per-channel enables and vertical-block restart on size writes. It sits between the PPU register file (mosaic register) and the BG/BG7 fetch pipelines.

## Interface
- `NUM_CH`, default 4: number of BG channels served.
- `SIZE_W`, default 4: width of size and counters. Block edge is `size+1` pixels; max block is 2^SIZE_W.
- `clk`  in  1  PPU master clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `dot_en`  in  1  dot clock enable; all state advances only when high, except reset and `size_we`.
- `newframe`  in  1  first line of frame (qualified by `dot_en`).
- `newline`  in  1  line boundary (qualified by `dot_en`).
- `period_start`  in  1  first visible dot of line (qualified by `dot_en`).
- `size_we`  in  1  register-write strobe for `size_in`, any cycle.
- `size_in`  in  SIZE_W  new mosaic size.
- `ch_enable_in`  in  NUM_CH  per-channel mosaic enable from register file.
- `pixel_strobe`  out  NUM_CH  high when channel i must capture a new pixel.
- `x_subtract`  out  NUM_CH×SIZE_W  offset to block's first column.
- `y_subtract`  out  NUM_CH×SIZE_W  offset to block's first line.
- `size_active`  out  SIZE_W  size currently in effect, for debug/BG7.

## Operation
- State: `x_ctr`, `y_ctr`, `size_act`, `size_pend`, `pend_flag`, `en_act[NUM_CH]`.
- Size write: on any `clk` with `size_we`, `size_pend<=size_in`, `pend_flag<=1`. A later write before the boundary overwrites `size_pend`.
- Line boundary: `dot_en & (newline | newframe)`. At a boundary:
  - `en_act<=ch_enable_in`.
  - If `pend_flag` is set, `size_act<=size_pend`, `pend_flag<=0` and `y_ctr<=0`. This is a vertical restart: the block begins on the new line.
  - If `size_we` coincides with the boundary, `size_in` is applied directly at that boundary and `pend_flag` ends at 0.
- Y priority, per `dot_en`:
  - `newframe` forces `y_ctr<=0`.
  - Otherwise a pending apply forces `y_ctr<=0`.
  - Otherwise `newline` sets `y_ctr <= (y_ctr>=size_act) ? 0 : y_ctr+1`.
- X, per `dot_en`: `period_start` forces `x_ctr<=0`. Otherwise `x_ctr <= (x_ctr>=size_act) ? 0 : x_ctr+1`. The `>=` comparison covers a size shrink that takes effect mid-block.
- Channel i is active when `en_act[i] & (size_act!=0)`.
  - Active: `pixel_strobe[i]=(x_ctr==0)`, `x_subtract[i]=x_ctr`, `y_subtract[i]=y_ctr`.
  - Inactive: `pixel_strobe[i]=1`, both subtracts 0.
- Counter arithmetic is SIZE_W bits, unsigned. The compare-wrap means no overflow is reachable, so increments never overflow.

## Timing
- Reset (async assert, sync deassert externally): all counters, `size_act`, `size_pend`, `pend_flag` and `en_act` are 0.
  - Outputs at reset: `pixel_strobe` all 1, subtracts all 0, `size_active=0`.
- Outputs are combinational from registers. Zero latency relative to counter state; a counter update is visible the cycle after the `dot_en` edge.
- Size written mid-line takes effect on the first dot of the next line. It never takes effect within a line.
- Reset asserted mid-line: returns to the reset state immediately. The first `newline` after release starts normal counting.
- `period_start` together with `newline` on the same dot: both X and Y actions apply.

## Structure
- Package `mosaic_pkg`:
  - `SIZE_W` default.
  - `typedef logic [SIZE_W-1:0] mosaic_size_t`.
  - Helper function `mosaic_next(ctr, size)` implementing the compare-wrap.
- Sub-module `mosaic_axis_ctr`: counter with clear, step enable and wrap-at-size. Instantiated twice, for X (step=`dot_en`) and Y (step=boundary).
- Per-channel output gating: a generate loop in the top module.

## Test plan
- Reset: hold `reset_n=0` → all `pixel_strobe=1`, subtracts 0. Release with no writes → outputs unchanged for a full line.
- Size 3, `ch_enable=4'b0001`, after one boundary:
  - ch0 `x_subtract` sequence is 0,1,2,3,0… and strobe fires every 4th dot.
  - ch1–3 `pixel_strobe` is constantly 1.
- Y counting: size 2 → `y_subtract` is 0,1,2,0 on successive lines. `newframe` mid-block → 0 on the next line.
- Mid-line write: `size_in=5` at dot 100 while `size_act=1` → X wrap stays at 1 until `newline`. The next line then has `y_subtract=0` and X period 6.
- Write on the boundary cycle: `size_we` with `newline` → new size active that line, and `pend_flag` is 0 afterwards.
- Shrink mid-block: `x_ctr=7` when size changes to 3 at a boundary without `period_start` → `x_ctr` wraps to 0 on the next dot.

Source files
------------

// File: rtl/mosaic_pkg.sv
// mosaic_pkg: shared mosaic size type, widths and the compare-wrap step helper
package mosaic_pkg;
  localparam int DEF_SIZE_W = 4;
  localparam int MAX_W = 16;
  typedef logic [DEF_SIZE_W-1:0] mosaic_size_t;
  typedef logic [MAX_W-1:0] mosaic_wide_t;
  // Wrap to zero once the counter reaches the block size; a counter already
  // past a freshly shrunk size also wraps instead of running on.
  function automatic mosaic_wide_t mosaic_next(input mosaic_wide_t ctr, input mosaic_wide_t size);
    return (ctr >= size) ? '0 : ctr + 16'd1;
  endfunction
endpackage

// File: rtl/mosaic_axis_ctr.sv
// mosaic_axis_ctr: block position counter with clear, step enable and wrap at size
module mosaic_axis_ctr
  import mosaic_pkg::*;
#(
  parameter int W = DEF_SIZE_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr_i,
  input  logic         step_i,
  input  logic [W-1:0] size_i,
  output logic [W-1:0] ctr_o
);
  logic [W-1:0] ctr_q, ctr_d;
  // clear wins over step; otherwise hold
  always_comb ctr_d = clr_i ? '0 : step_i ? W'(mosaic_next(MAX_W'(ctr_q), MAX_W'(size_i))) : ctr_q;
  // counter register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ctr_q <= '0;
    else ctr_q <= ctr_d;
  assign ctr_o = ctr_q;
endmodule

// File: rtl/mosaic_ctrl.sv
// mosaic_ctrl: multi-channel BG mosaic strobe and subtract generator
module mosaic_ctrl
  import mosaic_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SIZE_W = DEF_SIZE_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     dot_en,
  input  logic                     newframe,
  input  logic                     newline,
  input  logic                     period_start,
  input  logic                     size_we,
  input  logic [SIZE_W-1:0]        size_in,
  input  logic [NUM_CH-1:0]        ch_enable_in,
  output logic [NUM_CH-1:0]        pixel_strobe,
  output logic [NUM_CH*SIZE_W-1:0] x_subtract,
  output logic [NUM_CH*SIZE_W-1:0] y_subtract,
  output logic [SIZE_W-1:0]        size_active
);
  logic boundary, apply;
  logic pend_q, pend_d;
  logic [SIZE_W-1:0] size_act_q, size_act_d, size_pend_q, size_pend_d, x_ctr, y_ctr;
  logic [NUM_CH-1:0] en_act_q, en_act_d;
  // a write on the boundary dot is applied at once instead of being parked
  always_comb begin
    boundary = dot_en & (newline | newframe);
    apply = boundary & (pend_q | size_we);
    size_pend_d = size_we ? size_in : size_pend_q;
    size_act_d = apply ? size_pend_d : size_act_q;
    pend_d = size_we ? ~boundary : boundary ? 1'b0 : pend_q;
    en_act_d = boundary ? ch_enable_in : en_act_q;
  end
  // size and channel-enable registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      size_act_q <= '0;
      size_pend_q <= '0;
      pend_q <= 1'b0;
      en_act_q <= '0;
    end else begin
      size_act_q <= size_act_d;
      size_pend_q <= size_pend_d;
      pend_q <= pend_d;
      en_act_q <= en_act_d;
    end
  mosaic_axis_ctr #(.W(SIZE_W)) u_x (
    .clk(clk), .reset_n(reset_n), .clr_i(dot_en & period_start), .step_i(dot_en),
    .size_i(size_act_q), .ctr_o(x_ctr)
  );
  mosaic_axis_ctr #(.W(SIZE_W)) u_y (
    .clk(clk), .reset_n(reset_n), .clr_i((dot_en & newframe) | apply), .step_i(dot_en & newline),
    .size_i(size_act_q), .ctr_o(y_ctr)
  );
  assign size_active = size_act_q;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic act;
    assign act = en_act_q[i] & (|size_act_q);
    assign pixel_strobe[i] = act ? (x_ctr == '0) : 1'b1;
    assign x_subtract[i*SIZE_W +: SIZE_W] = act ? x_ctr : '0;
    assign y_subtract[i*SIZE_W +: SIZE_W] = act ? y_ctr : '0;
  end
endmodule

// File: tb/tb_mosaic_ctrl.sv
// tb_mosaic_ctrl: directed and random checks of mosaic_ctrl against a behavioural model
module tb_mosaic_ctrl;
  localparam int N = 4;
  localparam int W = 4;
  logic clk = 1'b0, reset_n = 1'b0, dot_en = 1'b0, newframe = 1'b0, newline = 1'b0;
  logic period_start = 1'b0, size_we = 1'b0;
  logic [W-1:0] size_in = '0;
  logic [N-1:0] ch_enable_in = '0;
  logic [N-1:0] pixel_strobe;
  logic [N*W-1:0] x_subtract, y_subtract;
  logic [W-1:0] size_active;
  int vectors = 0, miscompares = 0;
  int mx, my, msz, mpsz;
  bit mpend;
  bit [N-1:0] men;

  always #5 clk = ~clk;

  mosaic_ctrl #(.NUM_CH(N), .SIZE_W(W)) dut (
    .clk(clk), .reset_n(reset_n), .dot_en(dot_en), .newframe(newframe), .newline(newline),
    .period_start(period_start), .size_we(size_we), .size_in(size_in),
    .ch_enable_in(ch_enable_in), .pixel_strobe(pixel_strobe), .x_subtract(x_subtract),
    .y_subtract(y_subtract), .size_active(size_active)
  );

  function automatic void model_reset();
    mx = 0; my = 0; msz = 0; mpsz = 0; mpend = 0; men = '0;
  endfunction

  // Block geometry: a size reaches the screen only on a line boundary, and
  // taking a new size restarts the vertical block on that line.
  function automatic void model_edge();
    bit bnd, take;
    bnd = dot_en && (newline || newframe);
    take = bnd && (mpend || size_we);
    if (dot_en) begin
      mx = period_start ? 0 : (mx >= msz ? 0 : mx + 1);
      if (newframe || take) my = 0;
      else if (newline) my = (my >= msz) ? 0 : my + 1;
    end
    if (size_we) mpsz = int'(size_in);
    if (take) msz = mpsz;
    if (bnd) men = ch_enable_in;
    if (size_we) mpend = !bnd;
    else if (bnd) mpend = 0;
  endfunction

  task automatic check(input string tag);
    logic [N-1:0] es;
    logic [N*W-1:0] ex, ey;
    for (int i = 0; i < N; i++) begin
      bit act;
      act = men[i] && msz != 0;
      es[i] = act ? (mx == 0) : 1'b1;
      ex[i*W +: W] = act ? W'(mx) : '0;
      ey[i*W +: W] = act ? W'(my) : '0;
    end
    vectors++;
    assert (pixel_strobe === es) else begin miscompares++; $error("FAIL %s strobe got %b exp %b", tag, pixel_strobe, es); end
    vectors++;
    assert (x_subtract === ex) else begin miscompares++; $error("FAIL %s x_sub got %h exp %h", tag, x_subtract, ex); end
    vectors++;
    assert (y_subtract === ey) else begin miscompares++; $error("FAIL %s y_sub got %h exp %h", tag, y_subtract, ey); end
    vectors++;
    assert (size_active === W'(msz)) else begin miscompares++; $error("FAIL %s size got %0d exp %0d", tag, size_active, msz); end
  endtask

  task automatic expect_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    assert (got === exp) else begin miscompares++; $error("FAIL %s got %0d exp %0d", tag, got, exp); end
  endtask

  task automatic step(input bit de, input bit ps, input bit nl, input bit nf, input bit we,
                      input logic [W-1:0] sz, input string tag);
    dot_en = de; period_start = ps; newline = nl; newframe = nf; size_we = we; size_in = sz;
    @(posedge clk);
    model_edge();
    #1 check(tag);
  endtask

  task automatic line(input int len, input int wr_dot, input logic [W-1:0] wr_val, input string tag);
    for (int d = 0; d < len; d++)
      step(1'b1, d == 0, d == len - 1, 1'b0, d == wr_dot, wr_val, tag);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    dot_en = 0; period_start = 0; newline = 0; newframe = 0; size_we = 0;
    #1 model_reset();
    check({tag, "_async"});
    @(posedge clk);
    #1 check({tag, "_hold"});
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #3 check("reset");
    @(posedge clk);
    #1 check("reset_hold");
    reset_n = 1'b1;
    line(20, -1, '0, "idle");
    ch_enable_in = 4'b0001;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, "wr3");
    line(20, -1, '0, "size3_apply");
    line(20, -1, '0, "size3_run");
    line(20, -1, '0, "size3_run2");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, "wr2");
    for (int l = 0; l < 5; l++) line(8, -1, '0, "y2");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, "newframe");
    line(8, -1, '0, "after_nf");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, "wr1");
    line(120, -1, '0, "size1");
    line(120, 100, 4'd5, "midwrite5");
    line(20, -1, '0, "size5");
    expect_val("size5_active", size_active, 4'd5);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd7, "bound_wr7");
    expect_val("bound_wr_size", size_active, 4'd7);
    line(20, -1, '0, "size7");
    line(20, -1, '0, "size7_b");
    ch_enable_in = 4'b1111;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9, "wr9");
    line(20, -1, '0, "size9");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, "shrink_ps");
    for (int d = 0; d < 7; d++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, "shrink_run");
    expect_val("x_at_7", x_subtract[3:0], 4'd7);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, "shrink_bnd");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, "shrink_wrap");
    expect_val("shrink_x0", x_subtract[3:0], 4'd0);
    expect_val("shrink_size", size_active, 4'd3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, "mid_reset_pre");
    do_reset("midline_reset");
    line(10, -1, '0, "post_reset");
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) do_reset("rand_reset");
      if ($urandom_range(0, 49) == 0) ch_enable_in = N'($urandom);
      step($urandom_range(0, 4) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 99) == 0, $urandom_range(0, 14) == 0, W'($urandom), "random");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
